fir_mac_datapath: RTL
=====================

Name: fir_mac_datapath

Overview:
- Serial multiply-accumulate datapath for the 32-tap FIR filter. It is the consumer side of the filter control sequencer.
- Each frame it accepts one input sample when data_in_en is high. It then accumulates 32 sample×coefficient products, addressed by data_counter and co_choose and gated by add_en.
- When out_en is asserted, it emits one rounded, saturated result.
- The coefficient register file is loaded through a simple write port.

Parameters:
- DATA_W, 16, signed input sample width.
- COEF_W, 16, signed coefficient width, Q1.15.
- TAPS, 32, delay-line and coefficient depth. Must equal 2^5, matching the 5-bit indices.
- ACC_W, 37, accumulator width (DATA_W+COEF_W+5). No internal overflow is possible.
- OUT_SHIFT, 15, right shift applied to the accumulator before output.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_in  in  DATA_W  signed input sample.
- data_in_en  in  1  write data_in into the delay line this cycle.
- data_counter  in  5  tap index; 0 selects the newest sample.
- co_choose  in  5  coefficient index.
- add_en  in  1  accumulate the product selected this cycle.
- out_en  in  1  this cycle's selection is the last of the frame; emit the result.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  5  coefficient write address.
- coef_wr_data  in  COEF_W  coefficient write data.
- data_out  out  16  signed filter output, held between frames.
- data_out_valid  out  1  one-cycle pulse when data_out updates.
- sat_flag  out  1  high together with data_out_valid when the result was clipped.

Behaviour:
- Reset (async, rst_n=0):
  - All 32 delay-line entries = 0; write pointer wp = 0.
  - All coefficients = 0.
  - Pipeline registers, add_en_d, out_en_d = 0; acc = 0.
  - data_out = 0, data_out_valid = 0, sat_flag = 0.
  - Any partial frame is discarded. No output pulse is produced for it after reset release.
- Delay line:
  - On data_in_en=1: buf[wp] <= data_in; wp <= wp+1, wrapping 31→0.
- Tap read (combinational from current state):
  - sample = buf[(wp-1-data_counter) mod 32]; coef = coef_rf[co_choose].
  - If data_in_en coincides with a read, the read uses the pre-write wp and contents.
- Coefficient write:
  - coef_rf[coef_wr_addr] <= coef_wr_data.
  - A read of the same address in the same cycle returns the old value.
- Stage 1 (registered):
  - p <= sample*coef, a signed 32-bit full product.
  - add_en_d <= add_en; out_en_d <= out_en.
- Stage 2:
  - sum = acc + (add_en_d ? sext(p) : 0).
  - If out_en_d=1:
    - r = (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half up.
    - data_out <= r clipped to [-32768, 32767].
    - sat_flag <= (r was clipped).
    - data_out_valid <= 1.
    - acc <= 0.
  - Else: acc <= sum; data_out_valid <= 0; sat_flag <= 0.
- Latency:
  - out_en high in cycle N → data_out_valid high in cycle N+2 for exactly one cycle.
  - The product selected in cycle N is included in that result.
- Frames:
  - out_en with add_en=0 emits acc as it stands.
  - Back-to-back out_en on consecutive cycles gives consecutive valid pulses; the second result covers only products after the first.
- add_en with out_en never asserted: acc keeps accumulating. It cannot overflow within 32 products.
- Index values are always in range (5 bits, TAPS=32); no range check is needed.

Test Plan:
- Reset mid-frame:
  - Stimulus: assert rst_n=0 during add_en cycles, release, send a full frame of zeros.
  - Required: data_out=0x0000, no valid pulse before the first out_en+2.
- Single tap, rounding:
  - Setup: coef[0]=0x4000, others 0.
  - data_in=0x1234, frame sweeping idx 0..31 → data_out=0x091A, valid 2 cycles after out_en.
  - data_in=0x1235 → 0x091B.
  - data_in=-0x1235 → 0xF6E6.
- Impulse/delay:
  - Setup: coef[k]=(k+1)*0x100.
  - Stimulus: one sample 0x4000, then zeros, one frame per sample.
  - Required: frame m outputs (m+1)*0x80 for m=0..31. Frame 32 (wrap) outputs 0.
- Saturation:
  - Setup: all coef=0x7FFF, constant input 0x7FFF for 32 frames.
  - Required: data_out=0x7FFF with sat_flag=1.
  - Repeat with input 0x8000 → 0x8000 (-32768), sat_flag=1.
- Simultaneous events:
  - coef write to address 3 while co_choose=3 → old value used; new value used from the next cycle.
  - data_in_en in the same cycle as a data_counter=0 read → previous newest sample used.
- Back-to-back frames:
  - out_en on two consecutive cycles with add_en=1 each → two valid pulses.
  - The second data_out equals the rounded single product, confirming acc cleared.

Source files
------------

// File: rtl/fir_mac_datapath.sv
// Serial MAC datapath for a 32-tap FIR: delay line, coefficient file, 2-stage multiply/accumulate.
// Latency: out_en in cycle N -> data_out_valid in cycle N+2 (product selected in cycle N included).
// No backpressure: the sequencer drives one selection per cycle and every result is emitted unconditionally.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   data_in, data_in_en         sample write into the circular delay line
//   data_counter, co_choose     tap index (0 = newest sample) and coefficient index
//   add_en, out_en              accumulate this selection / close the frame and emit
//   coef_wr_en/addr/data        coefficient register file write port
//   data_out, data_out_valid    rounded, saturated result and its one-cycle strobe
//   sat_flag                    result was clipped (qualifies data_out_valid)
module fir_mac_datapath #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 32,
  parameter int ACC_W     = 37,
  parameter int OUT_SHIFT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_en,
  input  logic [4:0]        data_counter,
  input  logic [4:0]        co_choose,
  input  logic              add_en,
  input  logic              out_en,
  input  logic              coef_wr_en,
  input  logic [4:0]        coef_wr_addr,
  input  logic [COEF_W-1:0] coef_wr_data,
  output logic [15:0]       data_out,
  output logic              data_out_valid,
  output logic              sat_flag
);

  localparam int PROD_W = DATA_W + COEF_W;

  // Rounding constant (half an output LSB) and clip limits, all at accumulator width.
  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] MAX_A = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] MIN_A = ACC_W'(-32'sd32768);

  logic signed [DATA_W-1:0] dline   [TAPS];
  logic signed [COEF_W-1:0] coef_rf [TAPS];
  logic [4:0]               wp;

  logic [4:0]               rd_idx;
  logic signed [DATA_W-1:0] sample;
  logic signed [COEF_W-1:0] coef;

  logic signed [PROD_W-1:0] prod;
  logic                     add_en_d;
  logic                     out_en_d;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  addend;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  rsum;
  logic signed [ACC_W-1:0]  rshift;
  logic                     clip_hi;
  logic                     clip_lo;

  // wp points at the next free slot, so the newest sample sits at wp-1.
  // 5-bit arithmetic gives the modulo-32 wrap for free.
  assign rd_idx = wp - 5'd1 - data_counter;
  assign sample = dline[rd_idx];
  assign coef   = coef_rf[co_choose];

  // Delay line: reads above see the pre-write contents when data_in_en coincides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) dline[i] <= '0;
      wp <= '0;
    end else if (data_in_en) begin
      dline[wp] <= data_in;
      wp        <= wp + 5'd1;
    end
  end

  // Coefficient file: same-cycle read of the written address returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) coef_rf[i] <= '0;
    end else if (coef_wr_en) begin
      coef_rf[coef_wr_addr] <= coef_wr_data;
    end
  end

  // Stage 1: full-precision product plus aligned control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      add_en_d <= 1'b0;
      out_en_d <= 1'b0;
    end else begin
      prod     <= PROD_W'(sample) * PROD_W'(coef);
      add_en_d <= add_en;
      out_en_d <= out_en;
    end
  end

  // Stage 2: accumulate, and on the frame's last selection round half up,
  // saturate to 16 bits and restart the accumulator from zero.
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign addend   = add_en_d ? prod_ext : '0;
  assign sum      = acc + addend;
  assign rsum     = sum + RND;
  assign rshift   = rsum >>> OUT_SHIFT;
  assign clip_hi  = rshift > MAX_A;
  assign clip_lo  = rshift < MIN_A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      sat_flag       <= 1'b0;
    end else if (out_en_d) begin
      acc            <= '0;
      data_out_valid <= 1'b1;
      sat_flag       <= clip_hi | clip_lo;
      if (clip_hi)      data_out <= 16'h7FFF;
      else if (clip_lo) data_out <= 16'h8000;
      else              data_out <= rshift[15:0];
    end else begin
      acc            <= sum;
      data_out_valid <= 1'b0;
      sat_flag       <= 1'b0;
    end
  end

endmodule
